// File: rtl/trig_hist_pkg.sv
// Shared constants and count word type for the trigger histogrammer and the command processor.
// Pure declarations: no latency, no backpressure.
package trig_hist_pkg;
  localparam int NBOARDS = 4;
  localparam int NCH     = 8;
  localparam int CNT_W   = 32;

  typedef logic [CNT_W-1:0] hist_word_t;

  localparam hist_word_t CNT_MAX = '1;
endpackage

// File: rtl/trigger_hist_accumulator_if.sv
// Hit inputs, board selection/clear from the processor and the histogram read-out bus.
// The bus carries no handshake; it is sampled every clock.
interface trigger_hist_accumulator_if #(
  parameter int NBOARDS = trig_hist_pkg::NBOARDS,
  parameter int NCH     = trig_hist_pkg::NCH,
  parameter int CNT_W   = trig_hist_pkg::CNT_W
);
  logic [NBOARDS*NCH-1:0] hits;
  logic [7:0]             histostosend;
  logic                   resethist;
  logic [CNT_W-1:0]       histos [NCH];
  logic [NCH-1:0]         sat_flags;

  modport master (
    output hits, histostosend, resethist,
    input  histos, sat_flags
  );

  modport slave (
    input  hits, histostosend, resethist,
    output histos, sat_flags
  );
endinterface

// File: rtl/hist_counter.sv
// One saturating hit counter; a clear loads the incoming hit so it is not lost.
// Single-cycle update, no backpressure.
module hist_counter #(
  parameter int CNT_W = trig_hist_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);
  assign sat = &count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= CNT_W'(inc);
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/trigger_hist_accumulator.sv
// Per-channel hit histogrammer: hit register, saturating counters, registered per-board read-out mux.
// Hit to histos: 3 edges; selection change: 1 edge. No backpressure, every hit is counted.
module trigger_hist_accumulator
  import trig_hist_pkg::*;
#(
  parameter int NBOARDS = trig_hist_pkg::NBOARDS,
  parameter int NCH     = trig_hist_pkg::NCH,
  parameter int CNT_W   = trig_hist_pkg::CNT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  trigger_hist_accumulator_if.slave   bus
);
  localparam int SEL_W = (NBOARDS > 1) ? $clog2(NBOARDS) : 1;

  logic [NBOARDS*NCH-1:0] hit_q;
  logic [CNT_W-1:0]       cnt [NBOARDS][NCH];
  logic [NCH-1:0]         sat [NBOARDS];
  logic [NBOARDS-1:0]     clr_brd;
  logic                   sel_ok;
  logic [SEL_W-1:0]       sel;

  // Out-of-range selections read as zero and clear nothing.
  assign sel_ok = (int'(bus.histostosend) < NBOARDS);
  assign sel    = SEL_W'(bus.histostosend);

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q <= '0;
    end else begin
      hit_q <= bus.hits;
    end
  end

  for (genvar b = 0; b < NBOARDS; b++) begin : g_brd
    assign clr_brd[b] = bus.resethist && sel_ok && (sel == SEL_W'(b));

    for (genvar c = 0; c < NCH; c++) begin : g_ch
      hist_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_brd[b]),
        .inc   (hit_q[b*NCH+c]),
        .count (cnt[b][c]),
        .sat   (sat[b][c])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !sel_ok) begin
      bus.histos    <= '{default: '0};
      bus.sat_flags <= '0;
    end else begin
      bus.histos    <= cnt[sel];
      bus.sat_flags <= sat[sel];
    end
  end
endmodule
